// File: rtl/mem_responder.sv
// 2**ADDR_W x DATA_W single-port RAM responder with clear sequencer, collision flag and saturating counters.
// Read latency 1 cycle (rd_valid pulse); no backpressure, strobes are silently dropped while busy.
module mem_responder #(
  parameter int ADDR_W         = 5,
  parameter int DATA_W         = 8,
  parameter int CNT_W          = 16,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  input  logic              read,
  input  logic              write,
  input  logic              clear_req,
  output logic              busy,
  output logic              rd_valid,
  output logic              err_collision,
  output logic [CNT_W-1:0]  wr_count,
  output logic [CNT_W-1:0]  rd_count
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic {ST_CLEAR, ST_IDLE} state_t;

  state_t              state_q;
  logic [ADDR_W-1:0]   ptr_q;
  logic                busy_q;
  logic [DATA_W-1:0]   data_out_q;
  logic                rd_valid_q;
  logic                err_q;
  logic [CNT_W-1:0]    wr_cnt_q, wr_cnt_d;
  logic [CNT_W-1:0]    rd_cnt_q, rd_cnt_d;
  logic [DATA_W-1:0]   mem_q [DEPTH];

  logic                idle;
  logic                do_wr, do_rd, do_col;
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_waddr;
  logic [DATA_W-1:0]   mem_wdata;

  // clear_req wins over any strobe in the same IDLE cycle
  always_comb begin
    idle   = (state_q == ST_IDLE);
    do_wr  = idle && !clear_req && write && !read;
    do_rd  = idle && !clear_req && read && !write;
    do_col = idle && !clear_req && read && write;
  end

  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = addr;
    mem_wdata = data_in;
    if (!reset) begin
      if (state_q == ST_CLEAR) begin
        mem_we    = 1'b1;
        mem_waddr = ptr_q;
        mem_wdata = '0;
      end else if (do_wr) begin
        mem_we = 1'b1;
      end
    end
  end

  always_comb begin
    wr_cnt_d = wr_cnt_q;
    rd_cnt_d = rd_cnt_q;
    if (do_wr && (wr_cnt_q != {CNT_W{1'b1}})) wr_cnt_d = wr_cnt_q + CNT_W'(1);
    if (do_rd && (rd_cnt_q != {CNT_W{1'b1}})) rd_cnt_d = rd_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;
      busy_q     <= (CLEAR_ON_RESET != 0);
      ptr_q      <= '0;
      data_out_q <= '0;
      rd_valid_q <= 1'b0;
      err_q      <= 1'b0;
      wr_cnt_q   <= '0;
      rd_cnt_q   <= '0;
    end else begin
      case (state_q)
        ST_CLEAR: begin
          rd_valid_q <= 1'b0;
          ptr_q      <= ptr_q + ADDR_W'(1);
          if (ptr_q == {ADDR_W{1'b1}}) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          rd_valid_q <= do_rd;
          if (do_rd) data_out_q <= mem_q[addr];
          if (do_col) err_q <= 1'b1;
          wr_cnt_q <= wr_cnt_d;
          rd_cnt_q <= rd_cnt_d;
          if (clear_req) begin
            state_q <= ST_CLEAR;
            busy_q  <= 1'b1;
            ptr_q   <= '0;
          end
        end
      endcase
    end
  end

  assign data_out      = data_out_q;
  assign busy          = busy_q;
  assign rd_valid      = rd_valid_q;
  assign err_collision = err_q;
  assign wr_count      = wr_cnt_q;
  assign rd_count      = rd_cnt_q;

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
Memory-side responder for the memory test interface: a 32 x 8 synchronous RAM that services single-cycle read/write strobes from the test initiator.
- On reset, and on request, it runs a built-in clear sequencer that zeroes every location.
- It flags illegal simultaneous read/write strobes.
- It keeps saturating access counters for the bench scoreboard.

Parameters:
ADDR_W, 5, address width; depth = 2**ADDR_W
DATA_W, 8, data width
CNT_W, 16, width of access counters
CLEAR_ON_RESET, 1, 1 = run clear sequence after reset; 0 = go straight to IDLE with contents undefined

Ports:
clk  input  1  clock, all logic on posedge
reset  input  1  synchronous, active-high reset
addr  input  ADDR_W  access address
data_in  input  DATA_W  write data
data_out  output  DATA_W  registered read data
read  input  1  read strobe, one access per cycle high
write  input  1  write strobe, one access per cycle high
clear_req  input  1  request full-memory clear (sampled in IDLE only)
busy  output  1  high while clearing; strobes ignored
rd_valid  output  1  one-cycle pulse: data_out valid for the read issued the previous cycle
err_collision  output  1  sticky: read and write sampled high together
wr_count  output  CNT_W  number of accepted writes, saturating
rd_count  output  CNT_W  number of accepted reads, saturating

Behaviour:
Reset (synchronous, active-high) sets:
- data_out = 0, rd_valid = 0, err_collision = 0, wr_count = 0, rd_count = 0.
- Clear pointer = 0.
- State = CLEAR (busy = 1) if CLEAR_ON_RESET = 1, else IDLE (busy = 0).

FSM states: CLEAR, IDLE.

CLEAR:
- Each cycle: mem[ptr] <= 0, ptr++.
- When ptr = 2**ADDR_W-1 has been written, go to IDLE next cycle.
- busy is 1 for exactly 2**ADDR_W cycles (32 at default).
- read, write and clear_req are ignored and not counted. rd_valid = 0. data_out holds its value.
- err_collision is not set.

IDLE, clear_req = 1:
- Go to CLEAR, ptr = 0. No access is performed that cycle even if read or write is high.
- busy rises on the next cycle.

IDLE, write = 1, read = 0:
- mem[addr] <= data_in at the edge.
- wr_count++ unless saturated at all-ones.

IDLE, read = 1, write = 0:
- data_out <= mem[addr] at the edge; rd_valid = 1 in the following cycle only.
- Read latency is 1 cycle.
- rd_count++ unless saturated.
- Read in the cycle after a write to the same address returns the new data.
- Back-to-back reads are allowed, one per cycle, with rd_valid high continuously.

IDLE, read = 1 and write = 1:
- No memory access; counters unchanged; rd_valid = 0 next cycle.
- err_collision <= 1, held until reset.
- clear_req does not clear err_collision.

IDLE, neither strobe: nothing changes; rd_valid = 0.

Further rules:
- Address wrap-around: none. Addresses are exactly ADDR_W bits, so every value is legal.
- Counters never wrap. All-ones holds until reset.
- Reset mid-clear: the sequence restarts from ptr = 0, with the full 2**ADDR_W busy cycles.
- Reset during a read: rd_valid = 0 next cycle.
- clear_req while busy is ignored (no restart).

Test Plan:
- Reset for 2 cycles, release -> busy = 1 for exactly 32 cycles then 0. Then read addr 0..31 -> every data_out = 0x00 with rd_valid one cycle after each read; rd_count = 32.
- IDLE: write 0xA5 to addr 3, next cycle read addr 3 -> data_out = 0xA5 and rd_valid = 1 the following cycle; wr_count = 1, rd_count = 1.
- IDLE: read = 1 and write = 1 with addr 7, data_in 0x3C -> err_collision = 1 and stays 1. A subsequent read of addr 7 returns its previous value. Counters unchanged by the collision cycle.
- Write 0xFF to all 32 addresses, pulse clear_req -> busy for 32 cycles. Reads then return 0x00 everywhere; wr_count = 32 is preserved.
- Assert reset at cycle 10 of a clear sequence, release -> busy lasts a fresh 32 cycles. Writes and reads during busy are not performed and not counted.
- With CNT_W = 4: issue 20 writes -> wr_count = 15 and holds; after reset -> 0.
